// File: rtl/lsc_uart_pkg.sv
// ---------------------------------------------------------------------------
// lsc_uart_pkg
// Shared definitions for the FIFO-buffered UART:
//   - TX / RX FSM state encodings
//   - parity mode constants
//   - helpers to mask a byte to the configured data width and to compute
//     the parity bit that goes on the line
// ---------------------------------------------------------------------------
package lsc_uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Zero every bit at or above data_w so 7-bit frames stay LSB-aligned.
    function automatic logic [7:0] mask_data(input logic [7:0] d, input int data_w);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < data_w) ? d[i] : 1'b0;
        end
        return m;
    endfunction

    // Line parity bit: XOR over the data bits, inverted for odd parity.
    function automatic logic calc_parity(input logic [7:0] d, input int data_w, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < data_w) begin
                p = p ^ d[i];
            end
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/lsc_sync_fifo.sv
// ---------------------------------------------------------------------------
// lsc_sync_fifo
// Single-clock FIFO with a registered first-word-fall-through read port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_en, wr_data    write request / data (ignored when full unless popping)
//   full              no free entry
//   rd_en             pop request (ignored when empty)
//   rd_data           registered head-of-queue value, valid while !empty
//   empty             no stored entry
//
// Pointers carry one extra wrap bit; full/empty are told apart by that MSB.
// ---------------------------------------------------------------------------
module lsc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_n;
    logic [WIDTH-1:0] rd_next;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = rd_en && !empty;
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_push  = wr_en && (!full || do_pop);
    assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_pop};

    // The write address can only match the next head when the FIFO is
    // (about to be) empty, so the incoming word is forwarded directly.
    always_comb begin
        rd_next = mem[rd_ptr_n[AW-1:0]];
        if (do_push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
            rd_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr <= rd_ptr_n;
            if (do_push || do_pop) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: rtl/lsc_uart_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// lsc_uart_fifo_ctrl
// Full-duplex UART with TX and RX FIFOs, runtime bit period, 7/8 data bits,
// optional parity, 1/2 stop bits and sticky error flags.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_period                    bit period minus 1 (latched at each frame start)
//   i_tx_data/i_tx_valid        TX byte push; o_tx_ready = TX FIFO not full
//   o_tx_idle                   TX FIFO empty and shifter idle
//   o_rx_data/o_rx_valid        RX FIFO head (registered FWFT); i_rx_ready pops
//   i_clr_err                   clears o_frame_err/o_parity_err/o_rx_overflow
//   i_rxd / o_txd               serial line in (asynchronous) / out
// ---------------------------------------------------------------------------
module lsc_uart_fifo_ctrl
    import lsc_uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int PERIOD_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [7:0]          i_tx_data,
    input  logic                i_tx_valid,
    output logic                o_tx_ready,
    output logic                o_tx_idle,
    output logic [7:0]          o_rx_data,
    output logic                o_rx_valid,
    input  logic                i_rx_ready,
    input  logic                i_clr_err,
    output logic                o_frame_err,
    output logic                o_parity_err,
    output logic                o_rx_overflow,
    input  logic                i_rxd,
    output logic                o_txd
);

    localparam logic [3:0]          LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0]          LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [PERIOD_W-1:0] P_ONE     = PERIOD_W'(1);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t           tx_state;
    logic [PERIOD_W-1:0] tx_cnt;
    logic [PERIOD_W-1:0] tx_period;
    logic [3:0]          tx_bit;
    logic [7:0]          tx_sh;
    logic                tx_par;
    logic                tx_full;
    logic                tx_empty;
    logic [7:0]          tx_head;
    logic                tx_push;
    logic                tx_tick;
    logic                tx_stop_done;
    logic                tx_load;

    assign tx_push      = i_tx_valid && !tx_full;
    assign tx_tick      = (tx_cnt == '0);
    assign tx_stop_done = (tx_state == TX_STOP) && tx_tick && (tx_bit == LAST_STOP);
    // Start a new frame from IDLE, or straight out of the last stop bit so
    // queued bytes go out with no idle gap.
    assign tx_load      = !tx_empty && ((tx_state == TX_IDLE) || tx_stop_done);

    lsc_sync_fifo #(
        .WIDTH(8),
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (tx_push),
        .wr_data(i_tx_data),
        .full   (tx_full),
        .rd_en  (tx_load),
        .rd_data(tx_head),
        .empty  (tx_empty)
    );

    always_ff @(posedge clk) begin
        if (tx_load) begin
            tx_sh     <= mask_data(tx_head, DATA_W);
            tx_par    <= calc_parity(tx_head, DATA_W, PARITY);
            tx_period <= i_period;
        end else if (tx_tick && ((tx_state == TX_START) || (tx_state == TX_DATA))) begin
            tx_sh <= tx_sh >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            o_txd    <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tx_load) begin
            tx_state <= TX_START;
            o_txd    <= 1'b0;
            tx_cnt   <= i_period;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    o_txd <= 1'b1;
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_state <= TX_DATA;
                        o_txd    <= tx_sh[0];
                        tx_cnt   <= tx_period;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt - P_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= tx_period;
                        if (tx_bit == LAST_DATA) begin
                            tx_bit <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx_state <= TX_PARITY;
                                o_txd    <= tx_par;
                            end else begin
                                tx_state <= TX_STOP;
                                o_txd    <= 1'b1;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            o_txd  <= tx_sh[0];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - P_ONE;
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        tx_state <= TX_STOP;
                        o_txd    <= 1'b1;
                        tx_cnt   <= tx_period;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt - P_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (tx_bit == LAST_STOP) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            tx_cnt <= tx_period;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - P_ONE;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    o_txd    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx_ready = !tx_full;
    assign o_tx_idle  = tx_empty && (tx_state == TX_IDLE);

    // ------------------------------------------------------------------
    // RX synchronizer: p0/p1 resynchronise, p2 is the previous p1 value
    // used for falling-edge detection.
    // ------------------------------------------------------------------
    logic rxd_p0;
    logic rxd_p1;
    logic rxd_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= i_rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t           rx_state;
    logic [PERIOD_W-1:0] rx_cnt;
    logic [PERIOD_W-1:0] rx_period;
    logic [PERIOD_W-1:0] rx_half;
    logic [3:0]          rx_bit;
    logic [DATA_W-1:0]   rx_sh;
    logic [7:0]          rx_byte;
    logic [7:0]          rx_data_q;
    logic                rx_par_bad;
    logic                rx_push;
    logic                rx_tick;
    logic                rx_full;
    logic                rx_empty;
    logic                frame_evt;
    logic                par_evt;
    logic                ovf_evt;

    assign rx_tick = (rx_cnt == '0);
    // (i_period+1)>>1 without needing an extra carry bit.
    assign rx_half = (i_period >> 1) + PERIOD_W'(i_period[0]);

    always_comb begin
        rx_byte               = '0;
        rx_byte[DATA_W-1:0]   = rx_sh;
    end

    always_ff @(posedge clk) begin
        if ((rx_state == RX_IDLE) && rxd_p2 && !rxd_p1) begin
            rx_period <= i_period;
        end
        if ((rx_state == RX_DATA) && rx_tick) begin
            rx_sh <= {rxd_p1, rx_sh[DATA_W-1:1]};
        end
        if ((rx_state == RX_STOP) && rx_tick) begin
            rx_data_q <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_par_bad <= 1'b0;
            rx_push    <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_p2 && !rxd_p1) begin
                        rx_state   <= RX_START;
                        rx_cnt     <= rx_half - P_ONE;
                        rx_par_bad <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        // A start bit that is high again at mid-bit is a glitch.
                        if (rxd_p1) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= rx_period;
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - P_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= rx_period;
                        if (rx_bit == LAST_DATA) begin
                            rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 4'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - P_ONE;
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_par_bad <= (rxd_p1 != calc_parity(rx_byte, DATA_W, PARITY));
                        rx_cnt     <= rx_period;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - P_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_state <= RX_IDLE;
                        rx_push  <= rxd_p1 && !rx_par_bad;
                    end else begin
                        rx_cnt <= rx_cnt - P_ONE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign frame_evt = (rx_state == RX_STOP) && rx_tick && !rxd_p1;
    assign par_evt   = (rx_state == RX_STOP) && rx_tick && rx_par_bad;
    // A full FIFO drops the byte instead of overwriting stored entries.
    assign ovf_evt   = rx_push && rx_full;

    lsc_sync_fifo #(
        .WIDTH(8),
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (rx_push && !rx_full),
        .wr_data(rx_data_q),
        .full   (rx_full),
        .rd_en  (i_rx_ready),
        .rd_data(o_rx_data),
        .empty  (rx_empty)
    );

    assign o_rx_valid = !rx_empty;

    // ------------------------------------------------------------------
    // Sticky error flags: a new event outranks a same-cycle clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            o_frame_err   <= 1'b0;
            o_parity_err  <= 1'b0;
            o_rx_overflow <= 1'b0;
        end else begin
            o_frame_err   <= frame_evt | (o_frame_err   & ~i_clr_err);
            o_parity_err  <= par_evt   | (o_parity_err  & ~i_clr_err);
            o_rx_overflow <= ovf_evt   | (o_rx_overflow & ~i_clr_err);
        end
    end

endmodule

// File: tb/tb_lsc_uart_fifo_ctrl.sv
module tb_lsc_uart_fifo_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT A: 8N1, default depths
    logic [15:0] a_period;
    logic [7:0]  a_tx_data;
    logic        a_tx_valid, a_rx_ready, a_clr, a_rxd;
    logic        a_tx_ready, a_tx_idle, a_rx_valid, a_ferr, a_perr, a_ovf, a_txd;
    logic [7:0]  a_rx_data;

    // DUT B: 8E1, 4-entry FIFOs, optional loopback
    logic [15:0] b_period;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid, b_rx_ready, b_clr;
    logic        b_tx_ready, b_tx_idle, b_rx_valid, b_ferr, b_perr, b_ovf, b_txd;
    logic [7:0]  b_rx_data;
    logic        loop, drv_rxd;
    logic        b_rxd;
    assign b_rxd = loop ? b_txd : drv_rxd;

    int n_checks = 0;
    int n_errors = 0;

    lsc_uart_fifo_ctrl #(
        .DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16), .PARITY(0), .STOP_BITS(1), .PERIOD_W(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .i_period(a_period),
        .i_tx_data(a_tx_data), .i_tx_valid(a_tx_valid), .o_tx_ready(a_tx_ready), .o_tx_idle(a_tx_idle),
        .o_rx_data(a_rx_data), .o_rx_valid(a_rx_valid), .i_rx_ready(a_rx_ready), .i_clr_err(a_clr),
        .o_frame_err(a_ferr), .o_parity_err(a_perr), .o_rx_overflow(a_ovf),
        .i_rxd(a_rxd), .o_txd(a_txd)
    );

    lsc_uart_fifo_ctrl #(
        .DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .PARITY(2), .STOP_BITS(1), .PERIOD_W(16)
    ) u_dut_b (
        .clk(clk), .reset(reset), .i_period(b_period),
        .i_tx_data(b_tx_data), .i_tx_valid(b_tx_valid), .o_tx_ready(b_tx_ready), .o_tx_idle(b_tx_idle),
        .o_rx_data(b_rx_data), .o_rx_valid(b_rx_valid), .i_rx_ready(b_rx_ready), .i_clr_err(b_clr),
        .o_frame_err(b_ferr), .o_parity_err(b_perr), .o_rx_overflow(b_ovf),
        .i_rxd(b_rxd), .o_txd(b_txd)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_ferr;
        logic       exp_perr;
        logic       exp_valid;
    } rxvec_t;

    rxvec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial frame into DUT B at 4 clk per bit: start, 8 data LSB first, parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drv_rxd = f[i];
            cycles(4);
        end
        drv_rxd = 1'b1;
    endtask

    task automatic push_b(input logic [7:0] d, input string nm);
        check(nm, b_tx_ready, 1);
        b_tx_data  = d;
        b_tx_valid = 1'b1;
        cycles(1);
        b_tx_valid = 1'b0;
    endtask

    task automatic pop_b(input logic [7:0] exp, input string nm);
        check({nm, "_valid"}, b_rx_valid, 1);
        check({nm, "_data"}, b_rx_data, exp);
        b_rx_ready = 1'b1;
        cycles(1);
        b_rx_ready = 1'b0;
    endtask

    task automatic clear_b;
        b_clr = 1'b1;
        cycles(1);
        b_clr = 1'b0;
        check("clr_ferr", b_ferr, 0);
        check("clr_perr", b_perr, 0);
        check("clr_ovf", b_ovf, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        logic       ok;
        logic       idle_ok;
        logic       quiet;
        int         waited;
        int         n;

        // Directed RX frames into DUT B (even parity): hand-computed parity bits.
        vecs[0] = '{data: 8'h01, par: 1'b0, stop: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b1, exp_valid: 1'b0};
        vecs[1] = '{data: 8'h55, par: 1'b0, stop: 1'b0, exp_ferr: 1'b1, exp_perr: 1'b0, exp_valid: 1'b0};
        vecs[2] = '{data: 8'h3C, par: 1'b0, stop: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0, exp_valid: 1'b1};
        vecs[3] = '{data: 8'h80, par: 1'b1, stop: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0, exp_valid: 1'b1};
        vecs[4] = '{data: 8'hC3, par: 1'b1, stop: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b1, exp_valid: 1'b0};

        reset = 1'b1;
        a_period = 16'd3; a_tx_data = '0; a_tx_valid = 0; a_rx_ready = 0; a_clr = 0; a_rxd = 1'b1;
        b_period = 16'd3; b_tx_data = '0; b_tx_valid = 0; b_rx_ready = 0; b_clr = 0;
        loop = 1'b0; drv_rxd = 1'b1;
        cycles(3);

        // Reset state
        check("rst_txd", a_txd, 1);
        check("rst_tx_ready", a_tx_ready, 1);
        check("rst_tx_idle", a_tx_idle, 1);
        check("rst_rx_valid", a_rx_valid, 0);
        check("rst_rx_data", a_rx_data, 0);
        check("rst_errs", {a_ferr, a_perr, a_ovf}, 0);
        check("rst_b_state", {b_txd, b_tx_ready, b_tx_idle, b_rx_valid, b_ferr, b_perr, b_ovf}, 7'b1110000);
        reset = 1'b0;
        cycles(2);

        // TX waveform of 0xA5 on 8N1, 4 clk per bit
        check("a_ready_before_push", a_tx_ready, 1);
        a_tx_data = 8'hA5; a_tx_valid = 1'b1;
        cycles(1);
        a_tx_valid = 1'b0;
        waited = 0;
        while (a_txd && waited < 3) begin
            cycles(1);
            waited++;
        end
        check("tx_start_latency", (a_txd == 1'b0) && (waited <= 2), 1);
        pat = 10'b1101001010;
        idle_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (b > 0 || c > 0) cycles(1);
                if (a_txd !== pat[b]) ok = 1'b0;
                if (a_tx_idle !== 1'b0) idle_ok = 1'b0;
            end
            check($sformatf("tx_bit%0d", b), ok, 1);
        end
        check("tx_idle_low_in_frame", idle_ok, 1);
        cycles(1);
        check("tx_idle_after_stop", a_tx_idle, 1);
        check("txd_high_after_stop", a_txd, 1);

        // Loopback on DUT B: three back-to-back bytes
        loop = 1'b1;
        push_b(8'h00, "lb_push0");
        push_b(8'hFF, "lb_push1");
        push_b(8'h3C, "lb_push2");
        n = 0;
        while (!b_tx_idle && n < 500) begin
            cycles(1);
            n++;
        end
        check("lb_no_idle_gap", n, 131);
        cycles(30);
        check("lb_errs", {b_ferr, b_perr, b_ovf}, 0);
        pop_b(8'h00, "lb_rx0");
        pop_b(8'hFF, "lb_rx1");
        pop_b(8'h3C, "lb_rx2");
        check("lb_empty", b_rx_valid, 0);
        loop = 1'b0;
        cycles(4);

        // Table of injected RX frames
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            cycles(8);
            check($sformatf("vec%0d_ferr", i), b_ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d_perr", i), b_perr, vecs[i].exp_perr);
            check($sformatf("vec%0d_ovf", i), b_ovf, 0);
            check($sformatf("vec%0d_valid", i), b_rx_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) pop_b(vecs[i].data, $sformatf("vec%0d", i));
            clear_b();
        end

        // One-cycle glitch with a longer bit period
        b_period = 16'd7;
        drv_rxd = 1'b0;
        cycles(1);
        drv_rxd = 1'b1;
        cycles(20);
        check("glitch_valid", b_rx_valid, 0);
        check("glitch_errs", {b_ferr, b_perr, b_ovf}, 0);
        b_period = 16'd3;
        cycles(2);

        // RX overflow: five frames into a 4-entry FIFO without popping
        send_frame(8'h11, 1'b0, 1'b1); cycles(8);
        send_frame(8'h27, 1'b0, 1'b1); cycles(8);
        send_frame(8'h80, 1'b1, 1'b1); cycles(8);
        send_frame(8'h07, 1'b1, 1'b1); cycles(8);
        check("ovf_not_yet", b_ovf, 0);
        send_frame(8'h99, 1'b0, 1'b1); cycles(8);
        check("ovf_set", b_ovf, 1);
        check("ovf_other_errs", {b_ferr, b_perr}, 0);
        pop_b(8'h11, "ovf_rx0");
        pop_b(8'h27, "ovf_rx1");
        pop_b(8'h80, "ovf_rx2");
        pop_b(8'h07, "ovf_rx3");
        check("ovf_drained", b_rx_valid, 0);
        clear_b();

        // Reset in the middle of a data bit
        push_b(8'hF0, "rst_push0");
        push_b(8'h0F, "rst_push1");
        push_b(8'hAA, "rst_push2");
        push_b(8'h81, "rst_push3");
        cycles(6);
        check("busy_before_reset", b_tx_idle, 0);
        reset = 1'b1;
        cycles(1);
        check("reset_txd", b_txd, 1);
        check("reset_tx_ready", b_tx_ready, 1);
        check("reset_tx_idle", b_tx_idle, 1);
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (b_txd !== 1'b1 || b_tx_idle !== 1'b1) quiet = 1'b0;
        end
        check("no_tx_after_reset", quiet, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
